mat_loader: RTL and testbench

- Hardware writer for the GEMM operand memories: the write-side counterpart to the C-matrix debug read port.
- Accepts a valid/ready stream of 32-bit words.
- Writes the words into the A or B operand BRAM as a rows x cols matrix, in row-major or transposed (column-major) layout.
- Sits between the host/DMA stream and the operand BRAM write ports of top_gemm; loading completes before top_gemm start.

---
 rtl/mp_types.sv | 14 +
 rtl/mat_addr_gen.sv | 47 ++++
 rtl/mat_loader.sv | 123 ++++++++++++
 tb/tb_mat_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_types.sv
// Shared types for the GEMM operand-memory loader.
package mp_types;

   // Loader control states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      FINISH = 2'd2
   } load_state_e;

   // Operand BRAM word-address width (65536 words).
   localparam int MEM_ADDR_W = 16;

endpackage

// File: rtl/mat_addr_gen.sv
// Row/column beat counters with incremental (multiplier-free) BRAM address
// generation for row-major or column-major operand layout.
module mat_addr_gen #(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIM_W-1:0]  rows,
   input  logic [DIM_W-1:0]  cols,
   input  logic              transpose,
   input  logic              advance,
   input  logic              clear,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [DIM_W-1:0] r;
   logic [DIM_W-1:0] c;

   // The current beat is the final element of the matrix.
   assign last = (r == rows - DIM_W'(1)) && (c == cols - DIM_W'(1));

   // Walk elements in stream (row-major) order; in column-major layout the
   // address strides by rows and restarts at the next row on column wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r    <= '0;
         c    <= '0;
         addr <= '0;
      end else if (clear) begin
         r    <= '0;
         c    <= '0;
         addr <= '0;
      end else if (advance) begin
         if (c == cols - DIM_W'(1)) begin
            c    <= '0;
            r    <= r + DIM_W'(1);
            addr <= transpose ? ADDR_W'(r + DIM_W'(1)) : addr + ADDR_W'(1);
         end else begin
            c    <= c + DIM_W'(1);
            addr <= transpose ? addr + ADDR_W'(rows) : addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/mat_loader.sv
// Streams 32-bit words into the A or B operand BRAM as a rows x cols matrix,
// row-major or transposed. Handshake: a word transfers on a rising clk edge
// where s_valid && s_ready; s_ready is only high in LOAD, and s_data/s_last
// must be held stable by the source while s_valid is high and s_ready low.
module mat_loader
   import mp_types::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = 32,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sel_b,
   input  logic              transpose,
   input  logic [DIM_W-1:0]  rows,
   input  logic [DIM_W-1:0]  cols,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              busy,
   output logic              done,
   output logic              err
);

   load_state_e       state;
   logic [DIM_W-1:0]  rows_q;
   logic [DIM_W-1:0]  cols_q;
   logic              tr_q;
   logic              accept;
   logic              start_ok;
   logic [63:0]       total;
   logic [ADDR_W-1:0] gen_addr;
   logic              gen_last;

   // Element count of the requested matrix, checked against BRAM depth at start.
   assign total    = 64'(rows) * 64'(cols);
   assign accept   = s_valid && s_ready;
   assign start_ok = (state == IDLE) && start;

   mat_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .rows      (rows_q),
      .cols      (cols_q),
      .transpose (tr_q),
      .advance   (accept),
      .clear     (start_ok),
      .addr      (gen_addr),
      .last      (gen_last)
   );

   // Control FSM: latches the job, registers one BRAM write per accepted beat
   // and ends on the final element or an early s_last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rows_q   <= '0;
         cols_q   <= '0;
         tr_q     <= 1'b0;
         s_ready  <= 1'b0;
         mem_we   <= 1'b0;
         mem_sel  <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rows_q  <= rows;
                  cols_q  <= cols;
                  tr_q    <= transpose;
                  mem_sel <= sel_b;
                  err     <= 1'b0;
                  if (rows == '0 || cols == '0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else if (total > (64'd1 << ADDR_W)) begin
                     err   <= 1'b1;
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state   <= LOAD;
                     busy    <= 1'b1;
                     s_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  mem_we   <= 1'b1;
                  mem_addr <= gen_addr;
                  mem_din  <= s_data;
                  if (gen_last || s_last) begin
                     state   <= FINISH;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     s_ready <= 1'b0;
                     if (gen_last != s_last) err <= 1'b1;
                  end
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_loader.sv
// Directed + randomized bench for mat_loader with a behavioural write model.
module tb_mat_loader;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int DIM_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              sel_b = 1'b0;
   logic              transpose = 1'b0;
   logic [DIM_W-1:0]  rows = '0;
   logic [DIM_W-1:0]  cols = '0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic              s_ready;
   logic              mem_we;
   logic              mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_we_cyc = 0;

   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [ADDR_W+DATA_W-1:0] got_q[$];
   logic                     sel_q[$];

   mat_loader #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DIM_W  (DIM_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sel_b     (sel_b),
      .transpose (transpose),
      .rows      (rows),
      .cols      (cols),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .mem_we    (mem_we),
      .mem_sel   (mem_sel),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Write/done monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (mem_we) begin
         got_q.push_back({mem_addr, mem_din});
         sel_q.push_back(mem_sel);
         last_we_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One load job: model the expected writes, drive start and the stream,
   // then score writes, done, err and handshake state.
   task automatic run_job(input int nr, input int nc, input bit sel, input bit tr,
                          input int last_at, input int vmode, input bit seq);
      int total;
      int nbeats;
      int idx;
      int g;
      int st_cyc;
      bit over;
      bit v;
      bit acc;
      bit err_exp;
      logic [DATA_W-1:0] words[$];
      total = nr * nc;
      over  = (total > 65536);
      if (over || total == 0) nbeats = 0;
      else if (last_at < total) nbeats = last_at + 1;
      else nbeats = total;
      err_exp = over || (total > 0 && last_at != total - 1);
      words.delete();
      exp_q.delete();
      for (int k = 0; k < nbeats; k++) begin
         int a;
         words.push_back(seq ? DATA_W'(k) : DATA_W'($urandom));
         a = tr ? ((k % nc) * nr + (k / nc)) : k;
         exp_q.push_back({ADDR_W'(a), words[k]});
      end
      got_q.delete();
      sel_q.delete();
      done_cnt = 0;

      rows = DIM_W'(nr); cols = DIM_W'(nc); sel_b = sel; transpose = tr; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      st_cyc = cyc;
      check("err_at_start", err, over);
      check("busy_at_start", busy, (nbeats > 0) || (total > 0 && !over));
      check("mem_sel_latch", mem_sel, sel);

      idx = 0; g = 0;
      while (idx < nbeats && g < 2000) begin
         if (g == 2) begin
            start = 1'b1; rows = 1; cols = 1; sel_b = ~sel;
         end else begin
            start = 1'b0; rows = DIM_W'(nr); cols = DIM_W'(nc); sel_b = sel;
         end
         case (vmode)
            0: v = 1'b1;
            1: v = (g % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         s_valid = v;
         s_data  = words[idx];
         s_last  = (idx == last_at);
         acc = v && s_ready;
         @(posedge clk); #1;
         g++;
         if (acc) idx++;
      end
      start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      rows = DIM_W'(nr); cols = DIM_W'(nc); sel_b = sel;
      check("beats_accepted", idx, nbeats);
      if (nbeats > 0) check("ready_drop", s_ready, 0);

      g = 0;
      while (done_cnt == 0 && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (2) begin @(posedge clk); #1; end

      check("done_count", done_cnt, 1);
      check("write_count", got_q.size(), nbeats);
      for (int k = 0; k < nbeats && k < got_q.size(); k++) begin
         check($sformatf("write%0d_addr_data", k), got_q[k], exp_q[k]);
         check($sformatf("write%0d_sel", k), sel_q[k], sel);
      end
      if (nbeats > 0)
         check("done_vs_last_write", (done_cyc >= last_we_cyc) && (done_cyc - last_we_cyc <= 1), 1);
      else
         check("done_soon", (done_cnt > 0) && (done_cyc - st_cyc <= 3), 1);
      check("err_end", err, err_exp);
      check("busy_end", busy, 0);
      check("ready_idle", s_ready, 0);
   endtask

   initial begin
      int g;
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_we", mem_we, 0);
      check("rst_s_ready", s_ready, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_mem_sel", mem_sel, 0);

      // Directed jobs.
      run_job(4, 4, 1'b0, 1'b0, 15, 0, 1'b1);
      run_job(2, 3, 1'b1, 1'b1, 5, 0, 1'b1);
      run_job(2, 3, 1'b0, 1'b1, 5, 0, 1'b1);
      run_job(3, 3, 1'b0, 1'b0, 8, 1, 1'b0);
      run_job(4, 4, 1'b1, 1'b0, 5, 0, 1'b0);
      run_job(4, 4, 1'b0, 1'b0, 15, 0, 1'b0);
      run_job(2, 2, 1'b0, 1'b0, 4, 2, 1'b0);
      run_job(0, 5, 1'b1, 1'b0, 0, 0, 1'b0);
      run_job(257, 257, 1'b0, 1'b0, 0, 0, 1'b0);
      run_job(3, 2, 1'b1, 1'b1, 5, 2, 1'b0);

      // Reset in the middle of a load.
      rows = 4; cols = 4; sel_b = 1'b0; transpose = 1'b0; start = 1'b1;
      got_q.delete();
      @(posedge clk); #1;
      start = 1'b0;
      g = 0;
      while (got_q.size() < 7 && g < 50) begin
         s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
         @(posedge clk); #1;
         g++;
      end
      check("mid_rst_writes_seen", got_q.size() >= 7, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_mem_we", mem_we, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_s_ready", s_ready, 0);
      s_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_job(4, 4, 1'b1, 1'b0, 15, 0, 1'b0);

      // Randomized jobs.
      for (int j = 0; j < 8; j++) begin
         int nr;
         int nc;
         nr = $urandom_range(1, 6);
         nc = $urandom_range(1, 6);
         run_job(nr, nc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 nr * nc - 1, $urandom_range(0, 2), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
